// File: rtl/fft_stage_sequencer.sv
// Stage controller for the radix-2 in-place FFT core.
// The controller walks through stages 0..FFT_N-1. In each stage it raises run
// and waits for the address generator to report agDone. It then holds run low
// for a drain window so that butterfly write-back can finish and the
// generator counter can clear.
//
// Handshake: run is a level request to the generator. agDone is accepted only
// while run is high and only after the first cycle of that run phase. A done
// left over from the previous stage therefore cannot end the new stage. The
// controller ignores agDone while draining.
module fft_stage_sequencer #(
  parameter int FFT_N          = 10,
  parameter int STAGE_COUNT_BW = 4,
  parameter int DRAIN_CYCLES   = 4,
  parameter int TIMEOUT_MARGIN = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      agDone,
  output logic                      run,
  output logic [STAGE_COUNT_BW-1:0] stageCount,
  output logic                      stageDone,
  output logic                      busy,
  output logic                      fftDone,
  output logic                      error,
  output logic [1:0]                dbgState
);

  localparam int HALF      = 1 << (FFT_N - 1);
  localparam int TMO_LIMIT = HALF + TIMEOUT_MARGIN;
  // The generator's done falls 2 cycles after run falls, so the drain window
  // is never shorter than 2 cycles.
  localparam int DRAIN_EFF = (DRAIN_CYCLES < 2) ? 2 : DRAIN_CYCLES;
  localparam int TMO_BW    = (TMO_LIMIT > 1) ? $clog2(TMO_LIMIT) : 1;
  localparam int DRAIN_BW  = $clog2(DRAIN_EFF);

  localparam logic [STAGE_COUNT_BW-1:0] LAST_STAGE = STAGE_COUNT_BW'(FFT_N - 1);
  localparam logic [TMO_BW-1:0]         TMO_LAST   = TMO_BW'(TMO_LIMIT - 1);
  localparam logic [DRAIN_BW-1:0]       DRAIN_LOAD = DRAIN_BW'(DRAIN_EFF - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } stateT;

  stateT               state;
  logic [TMO_BW-1:0]   tmoCnt;
  logic [DRAIN_BW-1:0] drainCnt;

  assign dbgState = state;

  // Stage sequencing FSM. All outputs are registered here. Priority order is
  // abort, then agDone, then timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      run        <= 1'b0;
      stageCount <= '0;
      stageDone  <= 1'b0;
      busy       <= 1'b0;
      fftDone    <= 1'b0;
      error      <= 1'b0;
      tmoCnt     <= '0;
      drainCnt   <= '0;
    end else begin
      stageDone <= 1'b0;
      fftDone   <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        run        <= 1'b0;
        stageCount <= '0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state      <= RUN;
              run        <= 1'b1;
              busy       <= 1'b1;
              error      <= 1'b0;
              stageCount <= '0;
              tmoCnt     <= '0;
            end
          end
          RUN: begin
            if (agDone && (tmoCnt != '0)) begin
              state     <= DRAIN;
              run       <= 1'b0;
              stageDone <= 1'b1;
              drainCnt  <= DRAIN_LOAD;
            end else if (tmoCnt == TMO_LAST) begin
              state      <= IDLE;
              run        <= 1'b0;
              busy       <= 1'b0;
              error      <= 1'b1;
              stageCount <= '0;
            end else begin
              tmoCnt <= tmoCnt + 1'b1;
            end
          end
          DRAIN: begin
            if (drainCnt == '0) begin
              if (stageCount == LAST_STAGE) begin
                state   <= FINISH;
                fftDone <= 1'b1;
              end else begin
                state      <= RUN;
                run        <= 1'b1;
                stageCount <= stageCount + 1'b1;
                tmoCnt     <= '0;
              end
            end else begin
              drainCnt <= drainCnt - 1'b1;
            end
          end
          FINISH: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            run   <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer. It uses three instances:
//   A: FFT_N=4, DRAIN=4 (main schedule, ignored start, timeout, abort)
//   B: FFT_N=10 defaults (full-length latency)
//   C: FFT_N=4, DRAIN=1 (drain floor, late generator done)
module tb_fft_stage_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A ----------------
  logic       startA = 1'b0, abortA = 1'b0, agDoneA, holdLowA = 1'b0;
  logic       runA, stageDoneA, busyA, fftDoneA, errorA;
  logic [3:0] stageCountA;
  logic [1:0] dbgStateA;
  logic [10:0] cntA = '0;

  fft_stage_sequencer #(.FFT_N(4), .STAGE_COUNT_BW(4), .DRAIN_CYCLES(4), .TIMEOUT_MARGIN(8)) dutA (
    .clk(clk), .rst(rst), .start(startA), .abort(abortA), .agDone(agDoneA),
    .run(runA), .stageCount(stageCountA), .stageDone(stageDoneA), .busy(busyA),
    .fftDone(fftDoneA), .error(errorA), .dbgState(dbgStateA)
  );

  // Ideal generator: done in the 9th run-high cycle. The counter clears while run is low.
  always @(posedge clk) cntA <= runA ? cntA + 11'd1 : 11'd0;
  assign agDoneA = runA && (cntA == 11'd8) && !holdLowA;

  // ---------------- DUT B ----------------
  logic       startB = 1'b0, abortB = 1'b0, agDoneB;
  logic       runB, stageDoneB, busyB, fftDoneB, errorB;
  logic [3:0] stageCountB;
  logic [1:0] dbgStateB;
  logic [10:0] cntB = '0;

  fft_stage_sequencer dutB (
    .clk(clk), .rst(rst), .start(startB), .abort(abortB), .agDone(agDoneB),
    .run(runB), .stageCount(stageCountB), .stageDone(stageDoneB), .busy(busyB),
    .fftDone(fftDoneB), .error(errorB), .dbgState(dbgStateB)
  );

  always @(posedge clk) cntB <= runB ? cntB + 11'd1 : 11'd0;
  assign agDoneB = runB && (cntB == 11'd512);

  // ---------------- DUT C ----------------
  logic       startC = 1'b0, abortC = 1'b0, agDoneC;
  logic       runC, stageDoneC, busyC, fftDoneC, errorC;
  logic [3:0] stageCountC;
  logic [1:0] dbgStateC;
  logic [10:0] cntC = '0;
  logic [1:0]  stretchC = '0;

  fft_stage_sequencer #(.FFT_N(4), .STAGE_COUNT_BW(4), .DRAIN_CYCLES(1), .TIMEOUT_MARGIN(8)) dutC (
    .clk(clk), .rst(rst), .start(startC), .abort(abortC), .agDone(agDoneC),
    .run(runC), .stageCount(stageCountC), .stageDone(stageDoneC), .busy(busyC),
    .fftDone(fftDoneC), .error(errorC), .dbgState(dbgStateC)
  );

  // Late generator: done stays high for 3 cycles after the ideal done cycle.
  // This reaches into the first cycle of the next run phase.
  always @(posedge clk) begin
    cntC <= runC ? cntC + 11'd1 : 11'd0;
    if (runC && (cntC == 11'd8)) stretchC <= 2'd3;
    else if (stretchC != 2'd0)   stretchC <= stretchC - 2'd1;
  end
  assign agDoneC = (runC && (cntC == 11'd8)) || (stretchC != 2'd0);

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int sdCount;
    int fftCycle;
    int expK;
    int expR;

    // Reset values.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_run", runA, 0);
    chk("rst_stage", stageCountA, 0);
    chk("rst_stagedone", stageDoneA, 0);
    chk("rst_busy", busyA, 0);
    chk("rst_fftdone", fftDoneA, 0);
    chk("rst_error", errorA, 0);
    chk("rst_state", dbgStateA, 0);
    tick();

    // A: full schedule. Period 13, fftDone in cycle 53. Starts in cycles 10 and 53 are ignored.
    startA = 1'b1;
    tick();
    for (int c = 1; c <= 54; c++) begin
      expK = (c - 1) / 13;
      expR = (c - 1) % 13;
      chk($sformatf("a_run_c%0d", c), runA, (c <= 52 && expR < 9) ? 1 : 0);
      chk($sformatf("a_stage_c%0d", c), stageCountA, (expK > 3) ? 3 : expK);
      chk($sformatf("a_stagedone_c%0d", c), stageDoneA, (c <= 49 && expR == 9) ? 1 : 0);
      chk($sformatf("a_fftdone_c%0d", c), fftDoneA, (c == 53) ? 1 : 0);
      chk($sformatf("a_busy_c%0d", c), busyA, (c <= 53) ? 1 : 0);
      startA = (c == 10 || c == 53 || c == 54);
      tick();
    end
    startA = 1'b0;
    // Cycle 55: the start sampled in cycle 54, after busy fell, begins stage 0.
    chk("a_restart_run", runA, 1);
    chk("a_restart_stage", stageCountA, 0);
    chk("a_restart_busy", busyA, 1);
    abortA = 1'b1;
    tick();
    abortA = 1'b0;
    chk("a_cleanup_idle", dbgStateA, 0);

    // A: timeout. After 16 RUN cycles without done, the controller flags error and goes idle.
    holdLowA = 1'b1;
    startA = 1'b1;
    tick();
    startA = 1'b0;
    repeat (15) tick();
    chk("tmo_c16_run", runA, 1);
    chk("tmo_c16_error", errorA, 0);
    tick();
    chk("tmo_error", errorA, 1);
    chk("tmo_run", runA, 0);
    chk("tmo_busy", busyA, 0);
    chk("tmo_fftdone", fftDoneA, 0);
    chk("tmo_stage", stageCountA, 0);
    holdLowA = 1'b0;
    startA = 1'b1;
    tick();
    startA = 1'b0;
    chk("tmo_clear_error", errorA, 0);
    chk("tmo_clear_run", runA, 1);

    // A: abort in the stage-2 done cycle (cycle 35 of this run).
    repeat (34) tick();
    chk("abt_pre_stage", stageCountA, 2);
    chk("abt_pre_agdone", agDoneA, 1);
    abortA = 1'b1;
    tick();
    abortA = 1'b0;
    chk("abt_run", runA, 0);
    chk("abt_stage", stageCountA, 0);
    chk("abt_stagedone", stageDoneA, 0);
    chk("abt_fftdone", fftDoneA, 0);
    chk("abt_busy", busyA, 0);
    chk("abt_state", dbgStateA, 0);
    chk("abt_error", errorA, 0);
    repeat (3) begin
      tick();
      chk("abt_no_pulse", stageDoneA | fftDoneA, 0);
    end

    // C: the drain floor is 2 and the period is 11. A late done in the first run cycle is ignored.
    startC = 1'b1;
    tick();
    startC = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      chk($sformatf("c_run_c%0d", c), runC, ((c >= 1 && c <= 9) || (c >= 12 && c <= 20)) ? 1 : 0);
      chk($sformatf("c_stagedone_c%0d", c), stageDoneC, (c == 10 || c == 21) ? 1 : 0);
      if (c == 12) chk("c_late_done_present", agDoneC, 1);
      tick();
    end

    // B: full-length FFT. fftDone comes 5171 cycles after start, with 10 stageDone pulses.
    startB = 1'b1;
    tick();
    startB = 1'b0;
    sdCount = 0;
    fftCycle = -1;
    for (int c = 1; c <= 6000 && fftCycle < 0; c++) begin
      if (stageDoneB) sdCount++;
      if (fftDoneB) fftCycle = c;
      tick();
    end
    chk("b_fft_latency", fftCycle, 5171);
    chk("b_stagedone_count", sdCount, 10);

    // Reset in the middle of an operation.
    startA = 1'b1;
    tick();
    startA = 1'b0;
    repeat (5) tick();
    chk("mid_pre_run", runA, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_run", runA, 0);
    chk("mid_rst_busy", busyA, 0);
    chk("mid_rst_stage", stageCountA, 0);
    chk("mid_rst_state", dbgStateA, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Top-level stage controller for the radix-2 in-place FFT core; sits directly upstream of the butterfly address generator.
- On start, steps through stages 0..FFT_N-1. For each stage it drives stageCount and holds run high until the generator reports done. It then drops run for a drain window so butterfly write-back completes and the generator counter clears.
- Signals whole-FFT completion, supports abort, and flags a stage timeout.

Parameters:
- FFT_N, 10, log2 of FFT length; stages = FFT_N, butterflies per stage = 2^(FFT_N-1).
- STAGE_COUNT_BW, 4, width of stageCount; requires FFT_N <= 2^STAGE_COUNT_BW.
- DRAIN_CYCLES, 4, run-low cycles between stages (butterfly pipeline depth); effective value = max(DRAIN_CYCLES, 2).
- TIMEOUT_MARGIN, 8, extra cycles allowed beyond 2^(FFT_N-1) before timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request FFT; sampled only in IDLE.
- abort  in  1  cancel from any state.
- agDone  in  1  done from address generator.
- run  out  1  to address generator run.
- stageCount  out  STAGE_COUNT_BW  current stage index.
- stageDone  out  1  one-cycle pulse when a stage's run phase ends.
- busy  out  1  high in any state except IDLE.
- fftDone  out  1  one-cycle pulse after the last stage drains.
- error  out  1  sticky timeout flag.

Behaviour:
- All outputs are registered. Reset values: run=0, stageCount=0, stageDone=0, busy=0, fftDone=0, error=0, state=IDLE.

States: IDLE, RUN, DRAIN, FINISH.

- IDLE:
  - start=1 and abort=0 → RUN next cycle with stageCount=0, run=1, busy=1, and error cleared.
  - start while busy is ignored.
- RUN:
  - run=1; a timeout counter increments each cycle.
  - agDone=1 → next cycle: DRAIN, run=0, stageDone=1 for that one cycle, drain counter loaded.
  - Timeout counter reaches 2^(FFT_N-1)+TIMEOUT_MARGIN without agDone → next cycle: IDLE, run=0, error=1, stageCount=0, no fftDone.
  - Timing: with run rising in cycle t, agDone arrives in cycle t+2^(FFT_N-1); run is high for 2^(FFT_N-1)+1 cycles.
- DRAIN:
  - run=0 for exactly the effective drain count.
  - agDone is ignored in this state, since the generator's done lags run fall by 2 cycles; this is why the floor of 2 exists.
  - Last drain cycle, stageCount==FFT_N-1 → FINISH.
  - Last drain cycle, otherwise → RUN with stageCount+1.
- FINISH:
  - fftDone=1 for one cycle, then IDLE. busy drops the cycle after FINISH.
  - stageCount holds FFT_N-1 until the next start.
- abort=1 in any state → IDLE next cycle: run=0, stageCount=0, no stageDone/fftDone pulse, error unchanged. abort beats agDone, timeout, and start in the same cycle.
- Per-stage period = 2^(FFT_N-1)+1+drain. Total latency from the start-sample cycle to the fftDone cycle = FFT_N×period+1.
- rst mid-operation returns everything to reset values at the next edge.

Test Plan:
- FFT_N=4, DRAIN_CYCLES=4, ideal generator model, start pulse in cycle 0:
  - Stage k: run high cycles 1+13k..9+13k, stageCount=k, stageDone at 10+13k.
  - fftDone=1 only in cycle 53; busy high in cycles 1..53.
- FFT_N=10 defaults, single start: fftDone exactly 5171 cycles after the start-sample cycle; exactly 10 stageDone pulses.
- FFT_N=4, DRAIN_CYCLES=1: effective drain is 2. agDone still high in the first cycle of the next RUN must not end that stage; stage period = 11.
- Hold agDone=0 after start (FFT_N=4, margin 8): error=1 and run=0 after 16 RUN cycles, busy=0, no fftDone. A following start clears error.
- Assert abort in the RUN cycle where stageCount=2 and agDone=1: next cycle IDLE, run=0, stageCount=0, no stageDone pulse, no fftDone.
- Assert start during DRAIN and in the fftDone cycle: both ignored. A start one cycle after busy falls begins a new stage 0.
